fpu_vec_runner: RTL
===================

Name: fpu_vec_runner

Overview:
- On-chip, parametrised stimulus/checker engine for the FPU.
- Host loads up to DEPTH vectors (a, b, op, expected result) into internal registers. On start, the block issues one vector per cycle to the FPU and samples the result LAT cycles later. It compares each result against the expected value and counts mismatches.
- Replaces file-driven bench stimulus with a synthesizable, width- and latency-generic runner placed beside the fpu instance.

Parameters:
- WIDTH, 64, operand/result width (32 or 64)
- OPW, 3, fpu_op width
- DEPTH, 16, vector storage entries (power of 2)
- AW, 4, log2(DEPTH)
- LAT, 4, FPU result latency in cycles (>=1)
- CW, 16, error counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ld_valid  in  1  load handshake valid
- ld_ready  out  1  load handshake ready
- ld_a  in  WIDTH  operand a to store
- ld_b  in  WIDTH  operand b to store
- ld_op  in  OPW  operation to store
- ld_exp  in  WIDTH  expected result to store
- start  in  1  begin run (pulse)
- clear  in  1  return from DONE to IDLE
- busy  out  1  high in ISSUE or DRAIN
- done  out  1  high in DONE
- fpu_a  out  WIDTH  registered operand a to FPU
- fpu_b  out  WIDTH  registered operand b to FPU
- fpu_op  out  OPW  registered op to FPU
- issue_valid  out  1  fpu_a/b/op carry a live vector this cycle
- fpu_out  in  WIDTH  FPU result
- res_valid  out  1  one-cycle pulse per checked result
- res_idx  out  AW  index of checked vector
- res_mismatch  out  1  fpu_out != expected (valid with res_valid)
- vec_count  out  AW+1  vectors loaded
- err_count  out  CW  mismatches, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; wr_ptr, rd_ptr, vec_count, err_count 0; pipeline tracker valids 0. Storage contents are not cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - ld_ready = (vec_count < DEPTH); this is combinational from state and count.
  - ld_valid & ld_ready writes entry vec_count[AW-1:0] and increments vec_count.
  - start with vec_count>0 -> ISSUE, rd_ptr=0. start with vec_count==0 -> DONE.
  - If start and a load handshake coincide, the load is accepted first and start sees the incremented count.
- ISSUE:
  - Each edge registers mem[rd_ptr] onto fpu_a/b/op with issue_valid=1, pushes {valid, rd_ptr, exp} into a LAT-deep tracker, and increments rd_ptr.
  - After issuing entry vec_count-1 -> DRAIN.
  - ld_ready=0. start is ignored.
- Tracker: a vector presented after edge t is compared at edge t+LAT against fpu_out. Then res_valid=1, res_idx=index, res_mismatch=(fpu_out!=exp) for exactly one cycle.
- err_count increments on each mismatch and holds at 2^CW-1.
- DRAIN:
  - issue_valid=0. fpu_a/b/op hold their last values.
  - When the tracker is empty and no result is pending -> DONE.
- DONE: done=1, busy=0. Counters hold.
  - clear -> IDLE, zeroing vec_count, err_count, wr_ptr and rd_ptr.
  - start without clear reruns the stored vectors: -> ISSUE with err_count zeroed.
- Throughput: N vectors complete in N+LAT+1 cycles from start to done.
- Reset mid-run (ISSUE/DRAIN) returns to IDLE immediately. No res_valid is emitted afterwards for in-flight vectors.

Test Plan:
- Load 3 vectors (a=1.0, b=2.0, op=0, exp=3.0 in WIDTH=64 IEEE), LAT=4, pulse start. Required: issue_valid high 3 cycles, then 3 res_valid pulses with idx 0,1,2 and mismatch=0, err_count=0, done high 8 cycles after start.
- Same load with entry 1 exp corrupted (bit 0 flipped). Required: res_mismatch only on idx 1, err_count=1.
- Attempt DEPTH+1 loads. Required: ld_ready drops after 16, vec_count=16, 17th write not accepted.
- start with no vectors loaded. Required: done next cycle, no issue_valid, no res_valid, err_count=0.
- Assert rst for one cycle mid-ISSUE after 2 issues. Required: state IDLE, busy=0, no further res_valid, vec_count=0.
- CW=2, 5 mismatching vectors. Required: err_count saturates at 3.

Source files
------------

// File: rtl/fpu_vec_runner_if.sv
// Purpose: load, control, FPU-drive and result/status bundle for the FPU vector runner.
// Latency: n/a (plain signal bundle, no logic).
// Backpressure: ld_valid/ld_ready handshake on loads; the FPU side has no backpressure.
// Ports: ld_* load channel, start/clear control, busy/done status, fpu_* FPU drive,
//        res_* per-result report, vec_count/err_count counters.
interface fpu_vec_runner_if #(
  parameter int WIDTH = 64,
  parameter int OPW   = 3,
  parameter int AW    = 4,
  parameter int CW    = 16
);
  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] ld_a;
  logic [WIDTH-1:0] ld_b;
  logic [OPW-1:0]   ld_op;
  logic [WIDTH-1:0] ld_exp;
  logic             start;
  logic             clear;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] fpu_a;
  logic [WIDTH-1:0] fpu_b;
  logic [OPW-1:0]   fpu_op;
  logic             issue_valid;
  logic [WIDTH-1:0] fpu_out;
  logic             res_valid;
  logic [AW-1:0]    res_idx;
  logic             res_mismatch;
  logic [AW:0]      vec_count;
  logic [CW-1:0]    err_count;

  // Runner side.
  modport slave (
    input  ld_valid, ld_a, ld_b, ld_op, ld_exp, start, clear, fpu_out,
    output ld_ready, busy, done, fpu_a, fpu_b, fpu_op, issue_valid,
           res_valid, res_idx, res_mismatch, vec_count, err_count
  );

  // Host / FPU side.
  modport master (
    output ld_valid, ld_a, ld_b, ld_op, ld_exp, start, clear, fpu_out,
    input  ld_ready, busy, done, fpu_a, fpu_b, fpu_op, issue_valid,
           res_valid, res_idx, res_mismatch, vec_count, err_count
  );
endinterface

// File: rtl/fpu_vec_runner.sv
// Purpose: stores up to DEPTH test vectors, streams them one per cycle into an FPU and checks results.
// Latency: N vectors go from start to done in N+LAT+1 cycles; each result is reported LAT cycles after issue.
// Backpressure: loads accepted only in IDLE while storage has room; the FPU stream is never stalled.
// Ports: clk, rst (async active-high) plus bus (fpu_vec_runner_if.slave) carrying the load channel,
//        start/clear, busy/done, FPU operands/op/issue_valid, fpu_out, res_* report and counters.
module fpu_vec_runner #(
  parameter int WIDTH = 64,
  parameter int OPW   = 3,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LAT   = 4,
  parameter int CW    = 16
) (
  input logic             clk,
  input logic             rst,
  fpu_vec_runner_if.slave bus
);

  typedef struct packed {
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } vec_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] ERR_MAX = '1;

  state_e state_q, state_d;

  logic [AW:0]      vec_count_q, vec_count_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    err_count_q, err_count_d;
  logic [WIDTH-1:0] fpu_a_q, fpu_a_d;
  logic [WIDTH-1:0] fpu_b_q, fpu_b_d;
  logic [OPW-1:0]   fpu_op_q, fpu_op_d;
  logic             issue_valid_q, issue_valid_d;
  logic             res_valid_q, res_valid_d;
  logic [AW-1:0]    res_idx_q, res_idx_d;
  logic             res_mismatch_q, res_mismatch_d;

  // In-flight tracker: stage 0 receives the vector issued this edge, stage LAT-1
  // is the one whose FPU result is on fpu_out now.
  logic [LAT-1:0]   trk_vld_q, trk_vld_d;
  logic [AW-1:0]    trk_idx_q [LAT];
  logic [AW-1:0]    trk_idx_d [LAT];
  logic [WIDTH-1:0] trk_exp_q [LAT];
  logic [WIDTH-1:0] trk_exp_d [LAT];

  // Vector storage is deliberately not reset.
  vec_t mem_q [DEPTH];
  vec_t ld_vec;
  vec_t rd_vec;

  logic        ld_ready;
  logic        busy;
  logic        done;
  logic        ld_fire;
  logic        last_issue;
  logic        trk_empty;
  logic        cmp_mismatch;
  logic [AW:0] cnt_eff;

  assign ld_vec.a   = bus.ld_a;
  assign ld_vec.b   = bus.ld_b;
  assign ld_vec.op  = bus.ld_op;
  assign ld_vec.exp = bus.ld_exp;
  assign rd_vec     = mem_q[rd_ptr_q];

  assign ld_fire    = bus.ld_valid & ld_ready;
  // A load in the same cycle as start counts toward the run.
  assign cnt_eff    = vec_count_q + {{AW{1'b0}}, ld_fire};
  assign last_issue = ({1'b0, rd_ptr_q} == (vec_count_q - (AW+1)'(1)));
  assign trk_empty  = ~|trk_vld_q;
  assign cmp_mismatch = trk_vld_q[LAT-1] && (bus.fpu_out != trk_exp_q[LAT-1]);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (cnt_eff != '0) ? S_ISSUE : S_DONE;
      S_ISSUE: if (last_issue) state_d = S_DRAIN;
      // Empty tracker means the final compare has already been reported.
      S_DRAIN: if (trk_empty) state_d = S_DONE;
      S_DONE: begin
        if (bus.clear)                              state_d = S_IDLE;
        else if (bus.start && vec_count_q != '0)    state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ld_ready = (state_q == S_IDLE) && (vec_count_q < DEPTH_V);
    busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done     = (state_q == S_DONE);
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    vec_count_d    = vec_count_q;
    rd_ptr_d       = rd_ptr_q;
    err_count_d    = err_count_q;
    fpu_a_d        = fpu_a_q;
    fpu_b_d        = fpu_b_q;
    fpu_op_d       = fpu_op_q;
    issue_valid_d  = 1'b0;
    res_valid_d    = trk_vld_q[LAT-1];
    res_idx_d      = trk_idx_q[LAT-1];
    res_mismatch_d = cmp_mismatch;

    if (cmp_mismatch && err_count_q != ERR_MAX) err_count_d = err_count_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        vec_count_d = cnt_eff;
        rd_ptr_d    = '0;
      end
      S_ISSUE: begin
        fpu_a_d       = rd_vec.a;
        fpu_b_d       = rd_vec.b;
        fpu_op_d      = rd_vec.op;
        issue_valid_d = 1'b1;
        rd_ptr_d      = rd_ptr_q + 1'b1;
      end
      S_DONE: begin
        if (bus.clear) begin
          vec_count_d = '0;
          err_count_d = '0;
          rd_ptr_d    = '0;
        end else if (bus.start && vec_count_q != '0) begin
          err_count_d = '0;
          rd_ptr_d    = '0;
        end
      end
      default: ;
    endcase
  end

  // ---------------- tracker shift ----------------
  always_comb begin
    trk_vld_d    = '0;
    trk_vld_d[0] = (state_q == S_ISSUE);
    trk_idx_d[0] = rd_ptr_q;
    trk_exp_d[0] = rd_vec.exp;
    for (int i = 1; i < LAT; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_idx_d[i] = trk_idx_q[i-1];
      trk_exp_d[i] = trk_exp_q[i-1];
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_count_q    <= '0;
      rd_ptr_q       <= '0;
      err_count_q    <= '0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      fpu_op_q       <= '0;
      issue_valid_q  <= 1'b0;
      res_valid_q    <= 1'b0;
      res_idx_q      <= '0;
      res_mismatch_q <= 1'b0;
      trk_vld_q      <= '0;
      for (int i = 0; i < LAT; i++) begin
        trk_idx_q[i] <= '0;
        trk_exp_q[i] <= '0;
      end
    end else begin
      vec_count_q    <= vec_count_d;
      rd_ptr_q       <= rd_ptr_d;
      err_count_q    <= err_count_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      fpu_op_q       <= fpu_op_d;
      issue_valid_q  <= issue_valid_d;
      res_valid_q    <= res_valid_d;
      res_idx_q      <= res_idx_d;
      res_mismatch_q <= res_mismatch_d;
      trk_vld_q      <= trk_vld_d;
      for (int i = 0; i < LAT; i++) begin
        trk_idx_q[i] <= trk_idx_d[i];
        trk_exp_q[i] <= trk_exp_d[i];
      end
    end
  end

  // Write address is the current count, so no separate write pointer is kept.
  always_ff @(posedge clk) begin
    if (ld_fire) mem_q[vec_count_q[AW-1:0]] <= ld_vec;
  end

  assign bus.ld_ready     = ld_ready;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.fpu_a        = fpu_a_q;
  assign bus.fpu_b        = fpu_b_q;
  assign bus.fpu_op       = fpu_op_q;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_idx      = res_idx_q;
  assign bus.res_mismatch = res_mismatch_q;
  assign bus.vec_count    = vec_count_q;
  assign bus.err_count    = err_count_q;

endmodule
